// File: rtl/e1ofn_rtl_bridge.sv
// Bridge between M-digit enable-1-of-N four-phase channels and clocked valid/ready streams.
// The receive and send halves are independent and share only the clock and reset.
//
// rx state        | meaning
// RX_WAIT_DATA    | waiting for every synchronised digit to be complete
// RX_WAIT_NEUTRAL | word captured, waiting for all rails to return to zero
//
// tx state        | meaning
// TX_IDLE         | snd_ready high, waiting for a word
// TX_WAIT_EN      | word latched, waiting for synchronised out_e high
// TX_WAIT_ACK     | rails driven, waiting for synchronised out_e low
module e1ofn_rtl_bridge #(
  parameter  int M = 9,
  parameter  int N = 2,
  localparam int B = $clog2(N),
  localparam int W = M * B
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [M*N-1:0]   in_rails,
  output logic             in_e,
  output logic [W-1:0]     rcv_data,
  output logic             rcv_valid,
  input  logic             rcv_ready,
  output logic [M*N-1:0]   out_rails,
  input  logic             out_e,
  input  logic [W-1:0]     snd_data,
  input  logic             snd_valid,
  output logic             snd_ready
);

  typedef enum logic {
    RX_WAIT_DATA,
    RX_WAIT_NEUTRAL
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_EN,
    TX_WAIT_ACK
  } tx_state_t;

  localparam logic [N-1:0] DIG_ONE = {{(N-1){1'b0}}, 1'b1};

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;

  logic [M*N-1:0] in_s1_q, in_s1_d;
  logic [M*N-1:0] in_s2_q, in_s2_d;
  logic           oute_s1_q, oute_s1_d;
  logic           oute_s2_q, oute_s2_d;

  logic           in_e_q, in_e_d;
  logic           rcv_valid_q, rcv_valid_d;
  logic [W-1:0]   rcv_data_q, rcv_data_d;

  logic           snd_ready_q, snd_ready_d;
  logic [W-1:0]   tx_word_q, tx_word_d;
  logic [M*N-1:0] out_rails_q, out_rails_d;

  logic [M-1:0]   dig_complete;
  logic [W-1:0]   rx_word;
  logic [N-1:0]   dig;
  logic           all_complete;
  logic           all_neutral;
  logic           rcv_full_next;

  // Saturating one-hot encoder: values beyond the rail count map to the top rail.
  function automatic logic [M*N-1:0] encode(input logic [W-1:0] w);
    logic [M*N-1:0] r;
    logic [B-1:0]   v;
    int             idx;
    r = '0;
    for (int i = 0; i < M; i++) begin
      v   = w[i*B +: B];
      idx = (int'(v) >= N) ? (N - 1) : int'(v);
      r[i*N + idx] = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    in_s1_d   = in_rails;
    in_s2_d   = in_s1_q;
    oute_s1_d = out_e;
    oute_s2_d = oute_s1_q;
  end

  // Multi-hot digits are treated as incomplete, so a rail glitch cannot be captured.
  always_comb begin
    dig_complete = '0;
    rx_word      = '0;
    dig          = '0;
    for (int i = 0; i < M; i++) begin
      dig = in_s2_q[i*N +: N];
      dig_complete[i] = (dig != '0) && ((dig & (dig - DIG_ONE)) == '0);
      for (int j = 0; j < N; j++) begin
        if (dig[j]) begin
          rx_word[i*B +: B] = B'(j);
        end
      end
    end
  end

  assign all_complete  = &dig_complete;
  assign all_neutral   = (in_s2_q == '0);
  assign rcv_full_next = rcv_valid_q && !rcv_ready;

  always_comb begin
    rx_state_d  = rx_state_q;
    rcv_valid_d = rcv_full_next;
    rcv_data_d  = rcv_data_q;
    in_e_d      = 1'b0;
    case (rx_state_q)
      RX_WAIT_DATA: begin
        if (!rcv_valid_q && all_complete) begin
          rcv_data_d  = rx_word;
          rcv_valid_d = 1'b1;
          in_e_d      = 1'b0;
          rx_state_d  = RX_WAIT_NEUTRAL;
        end else begin
          in_e_d = !rcv_full_next;
        end
      end
      RX_WAIT_NEUTRAL: begin
        if (all_neutral) begin
          in_e_d     = !rcv_full_next;
          rx_state_d = RX_WAIT_DATA;
        end
      end
      default: begin
        rx_state_d = RX_WAIT_DATA;
      end
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    snd_ready_d = snd_ready_q;
    tx_word_d   = tx_word_q;
    out_rails_d = out_rails_q;
    case (tx_state_q)
      TX_IDLE: begin
        snd_ready_d = 1'b1;
        if (snd_valid && snd_ready_q) begin
          tx_word_d   = snd_data;
          snd_ready_d = 1'b0;
          tx_state_d  = TX_WAIT_EN;
        end
      end
      TX_WAIT_EN: begin
        snd_ready_d = 1'b0;
        if (oute_s2_q) begin
          out_rails_d = encode(tx_word_q);
          tx_state_d  = TX_WAIT_ACK;
        end
      end
      TX_WAIT_ACK: begin
        snd_ready_d = 1'b0;
        if (!oute_s2_q) begin
          out_rails_d = '0;
          snd_ready_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: begin
        out_rails_d = '0;
        snd_ready_d = 1'b0;
        tx_state_d  = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      oute_s1_q   <= 1'b0;
      oute_s2_q   <= 1'b0;
      rx_state_q  <= RX_WAIT_DATA;
      in_e_q      <= 1'b0;
      rcv_valid_q <= 1'b0;
      rcv_data_q  <= '0;
      tx_state_q  <= TX_IDLE;
      snd_ready_q <= 1'b0;
      tx_word_q   <= '0;
      out_rails_q <= '0;
    end else begin
      in_s1_q     <= in_s1_d;
      in_s2_q     <= in_s2_d;
      oute_s1_q   <= oute_s1_d;
      oute_s2_q   <= oute_s2_d;
      rx_state_q  <= rx_state_d;
      in_e_q      <= in_e_d;
      rcv_valid_q <= rcv_valid_d;
      rcv_data_q  <= rcv_data_d;
      tx_state_q  <= tx_state_d;
      snd_ready_q <= snd_ready_d;
      tx_word_q   <= tx_word_d;
      out_rails_q <= out_rails_d;
    end
  end

  assign in_e      = in_e_q;
  assign rcv_valid = rcv_valid_q;
  assign rcv_data  = rcv_data_q;
  assign snd_ready = snd_ready_q;
  assign out_rails = out_rails_q;

endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// Directed plus randomized bench for e1ofn_rtl_bridge (M=9, N=2).
// Expected values come from a token-level model of the e1ofN encoding and handshake timing.
module tb_e1ofn_rtl_bridge;

  localparam int M = 9;
  localparam int N = 2;
  localparam int B = 1;
  localparam int W = M * B;

  logic           CLK;
  logic           RESET;
  logic [M*N-1:0] in_rails;
  logic           in_e;
  logic [W-1:0]   rcv_data;
  logic           rcv_valid;
  logic           rcv_ready;
  logic [M*N-1:0] out_rails;
  logic           out_e;
  logic [W-1:0]   snd_data;
  logic           snd_valid;
  logic           snd_ready;

  int n_cmp = 0;
  int n_err = 0;

  e1ofn_rtl_bridge #(.M(M), .N(N)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_rails  (in_rails),
    .in_e      (in_e),
    .rcv_data  (rcv_data),
    .rcv_valid (rcv_valid),
    .rcv_ready (rcv_ready),
    .out_rails (out_rails),
    .out_e     (out_e),
    .snd_data  (snd_data),
    .snd_valid (snd_valid),
    .snd_ready (snd_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Digit i carries value v by raising rail i*N+v; values >= N land on rail N-1.
  function automatic logic [M*N-1:0] enc(input logic [W-1:0] w);
    logic [M*N-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < M; i++) begin
      v = (int'(w) >> (i * B)) & ((1 << B) - 1);
      if (v > N - 1) v = N - 1;
      r[i*N + v] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [M*N-1:0] r;
    logic [W-1:0]   w;
    logic [W-1:0]   w2;
    logic           any_rail;
    int             d;
    int             h;
    int             consume_e;
    int             pre;

    RESET     = 1'b1;
    in_rails  = '0;
    out_e     = 1'b1;
    rcv_ready = 1'b0;
    snd_valid = 1'b0;
    snd_data  = '0;

    // Reset behaviour
    repeat (3) tick();
    check("rst_in_e", 32'(in_e), 32'd0);
    check("rst_out_rails", 32'(out_rails), 32'd0);
    check("rst_rcv_valid", 32'(rcv_valid), 32'd0);
    check("rst_rcv_data", 32'(rcv_data), 32'd0);
    check("rst_snd_ready", 32'(snd_ready), 32'd0);
    RESET = 1'b0;
    tick();
    check("rel_in_e", 32'(in_e), 32'd1);
    check("rel_snd_ready", 32'(snd_ready), 32'd1);

    // Receive 0x165 with three-edge latency and backpressure
    in_rails = enc(9'h165);
    tick();
    tick();
    check("rx165_early_valid", 32'(rcv_valid), 32'd0);
    check("rx165_early_in_e", 32'(in_e), 32'd1);
    tick();
    check("rx165_valid", 32'(rcv_valid), 32'd1);
    check("rx165_data", 32'(rcv_data), 32'h165);
    check("rx165_in_e", 32'(in_e), 32'd0);
    in_rails = '0;
    repeat (5) tick();
    check("rx165_hold_in_e", 32'(in_e), 32'd0);
    check("rx165_hold_valid", 32'(rcv_valid), 32'd1);
    check("rx165_hold_data", 32'(rcv_data), 32'h165);
    rcv_ready = 1'b1;
    tick();
    rcv_ready = 1'b0;
    check("rx165_consumed", 32'(rcv_valid), 32'd0);
    check("rx165_in_e_back", 32'(in_e), 32'd1);

    // Multi-hot digit 3 must not capture
    r = enc(9'h0F0);
    r[7:6] = 2'b11;
    in_rails = r;
    repeat (6) tick();
    check("mhot_no_valid", 32'(rcv_valid), 32'd0);
    check("mhot_in_e", 32'(in_e), 32'd1);
    in_rails = enc(9'h0F0);
    repeat (3) tick();
    check("mhot_fixed_valid", 32'(rcv_valid), 32'd1);
    check("mhot_fixed_data", 32'(rcv_data), 32'h0F0);
    // Consume and release rails together
    in_rails  = '0;
    rcv_ready = 1'b1;
    tick();
    rcv_ready = 1'b0;
    check("mhot_consumed", 32'(rcv_valid), 32'd0);
    check("mhot_in_e_low", 32'(in_e), 32'd0);
    tick();
    tick();
    check("mhot_in_e_high", 32'(in_e), 32'd1);

    // Neutral digit 8 must not capture
    r = enc(9'h0AB);
    r[17:16] = 2'b00;
    in_rails = r;
    repeat (6) tick();
    check("part_no_valid", 32'(rcv_valid), 32'd0);
    check("part_in_e", 32'(in_e), 32'd1);
    in_rails = enc(9'h0AB);
    repeat (3) tick();
    check("part_fixed_valid", 32'(rcv_valid), 32'd1);
    check("part_fixed_data", 32'(rcv_data), 32'h0AB);
    in_rails  = '0;
    rcv_ready = 1'b1;
    tick();
    rcv_ready = 1'b0;
    repeat (3) tick();
    check("part_in_e_back", 32'(in_e), 32'd1);

    // Random receive tokens; in_e returns at max(consume edge, neutral + 3 edges)
    for (int k = 0; k < 6; k++) begin
      w = W'($urandom);
      in_rails = enc(w);
      repeat (3) tick();
      check("rxr_valid", 32'(rcv_valid), 32'd1);
      check("rxr_data", 32'(rcv_data), 32'(w));
      in_rails  = '0;
      d         = $urandom_range(0, 5);
      consume_e = d + 1;
      for (int e = 1; e <= 8; e++) begin
        rcv_ready = (e == consume_e);
        tick();
        rcv_ready = 1'b0;
        check("rxr_in_e", 32'(in_e), 32'((e >= 3) && (e >= consume_e)));
        check("rxr_valid_trk", 32'(rcv_valid), 32'(e < consume_e));
      end
    end

    // Send 0x0A3 with out_e already high
    snd_data  = 9'h0A3;
    snd_valid = 1'b1;
    tick();
    snd_valid = 1'b0;
    check("tx0a3_snd_ready", 32'(snd_ready), 32'd0);
    check("tx0a3_rails_pre", 32'(out_rails), 32'd0);
    tick();
    check("tx0a3_rails", 32'(out_rails), 32'(enc(9'h0A3)));
    out_e = 1'b0;
    tick();
    tick();
    check("tx0a3_rails_hold", 32'(out_rails), 32'(enc(9'h0A3)));
    check("tx0a3_busy", 32'(snd_ready), 32'd0);
    tick();
    check("tx0a3_rails_rtz", 32'(out_rails), 32'd0);
    check("tx0a3_ready_back", 32'(snd_ready), 32'd1);

    // Send with out_e low: rails wait for out_e to rise
    snd_data  = 9'h15A;
    snd_valid = 1'b1;
    tick();
    snd_valid = 1'b0;
    check("tx15a_snd_ready", 32'(snd_ready), 32'd0);
    any_rail = 1'b0;
    repeat (5) begin
      tick();
      any_rail = any_rail | (|out_rails);
    end
    check("tx15a_no_rails", 32'(any_rail), 32'd0);
    out_e = 1'b1;
    tick();
    tick();
    check("tx15a_rails_pre", 32'(out_rails), 32'd0);
    tick();
    check("tx15a_rails", 32'(out_rails), 32'(enc(9'h15A)));
    out_e = 1'b0;
    repeat (3) tick();
    check("tx15a_rails_rtz", 32'(out_rails), 32'd0);
    check("tx15a_ready_back", 32'(snd_ready), 32'd1);

    // Random send tokens with random enable timing
    for (int k = 0; k < 6; k++) begin
      w   = W'($urandom);
      pre = $urandom_range(0, 1);
      if (pre != 0) begin
        out_e = 1'b1;
        repeat (3) tick();
      end
      snd_data  = w;
      snd_valid = 1'b1;
      tick();
      snd_valid = 1'b0;
      check("txr_accept", 32'(snd_ready), 32'd0);
      if (pre != 0) begin
        tick();
        check("txr_rails_pre", 32'(out_rails), 32'(enc(w)));
      end else begin
        d = $urandom_range(0, 3);
        for (int e = 0; e < d; e++) begin
          tick();
          check("txr_wait_en", 32'(out_rails), 32'd0);
        end
        out_e = 1'b1;
        tick();
        tick();
        check("txr_sync_en", 32'(out_rails), 32'd0);
        tick();
        check("txr_rails", 32'(out_rails), 32'(enc(w)));
      end
      h = $urandom_range(0, 3);
      for (int e = 0; e < h; e++) begin
        tick();
        check("txr_hold", 32'(out_rails), 32'(enc(w)));
      end
      out_e = 1'b0;
      tick();
      tick();
      check("txr_ack_pre", 32'(out_rails), 32'(enc(w)));
      tick();
      check("txr_rtz", 32'(out_rails), 32'd0);
      check("txr_ready", 32'(snd_ready), 32'd1);
    end

    // Both halves active at once
    out_e = 1'b1;
    repeat (3) tick();
    w  = W'($urandom);
    w2 = W'($urandom);
    in_rails  = enc(w);
    snd_data  = w2;
    snd_valid = 1'b1;
    tick();
    snd_valid = 1'b0;
    check("dual_snd_ready", 32'(snd_ready), 32'd0);
    check("dual_rx_early", 32'(rcv_valid), 32'd0);
    tick();
    check("dual_tx_rails", 32'(out_rails), 32'(enc(w2)));
    check("dual_rx_early2", 32'(rcv_valid), 32'd0);
    tick();
    check("dual_rx_valid", 32'(rcv_valid), 32'd1);
    check("dual_rx_data", 32'(rcv_data), 32'(w));
    check("dual_tx_hold", 32'(out_rails), 32'(enc(w2)));

    // Reset mid-token on both halves
    RESET    = 1'b1;
    in_rails = '0;
    #1;
    check("midrst_rails", 32'(out_rails), 32'd0);
    check("midrst_valid", 32'(rcv_valid), 32'd0);
    check("midrst_in_e", 32'(in_e), 32'd0);
    check("midrst_snd_ready", 32'(snd_ready), 32'd0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("midrst_rel_snd_ready", 32'(snd_ready), 32'd1);
    check("midrst_rel_in_e", 32'(in_e), 32'd1);
    check("midrst_rel_data", 32'(rcv_data), 32'd0);
    any_rail = 1'b0;
    repeat (8) begin
      tick();
      any_rail = any_rail | (|out_rails);
    end
    check("midrst_no_resend", 32'(any_rail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
